// File: rtl/parallel_in_serial_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parallel_in_serial_out                                                     |
// | Loads a WIDTH-bit word over valid/ready, shifts it out one bit per clk.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module parallel_in_serial_out #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pdata,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_last_q, sout_last_d;

  logic             at_last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // The shift register always presents the next bit to send at one fixed end.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign first_bit  = pdata[0];
      assign load_rest  = pdata >> 1;
      assign next_bit   = sr_q[0];
      assign shift_rest = sr_q >> 1;
    end else begin : g_msb_first
      assign first_bit  = pdata[WIDTH-1];
      assign load_rest  = pdata << 1;
      assign next_bit   = sr_q[WIDTH-1];
      assign shift_rest = sr_q << 1;
    end
  endgenerate

  assign at_last    = (state_q == SHIFT) && (count_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || at_last;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sr_d         = sr_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    sout_last_d  = sout_last_q;
    if (accept) begin
      // Also covers the gapless case: a new word replaces the final bit.
      state_d      = SHIFT;
      count_d      = '0;
      sr_d         = load_rest;
      sout_d       = first_bit;
      sout_valid_d = 1'b1;
      sout_last_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d      = IDLE;
        count_d      = '0;
        sr_d         = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
      end else begin
        count_d      = count_q + CW'(1);
        sr_d         = shift_rest;
        sout_d       = next_bit;
        sout_valid_d = 1'b1;
        sout_last_d  = ((count_q + CW'(1)) == LAST_CNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      sr_q         <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sr_q         <= sr_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_parallel_in_serial_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parallel_in_serial_out                                                  |
// | Scoreboard bench: LSB-first and MSB-first instances, bit and word checks.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_parallel_in_serial_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv_a, lv_b;
  logic [3:0] pdata_a, pdata_b;
  logic       lr_a, sout_a, sv_a, sl_a, busy_a;
  logic       lr_b, sout_b, sv_b, sl_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Queue entries are {bit, last}; word queues hold the receiver's expected word.
  logic [1:0] qa_bits[$];
  logic [1:0] qb_bits[$];
  logic [3:0] qa_words[$];
  logic [3:0] qb_words[$];

  logic [3:0] rx_a, rx_b;
  logic       lastd_a, lastd_b;

  always #5 clk = ~clk;

  parallel_in_serial_out #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a), .pdata(pdata_a),
    .sout(sout_a), .sout_valid(sv_a), .sout_last(sl_a), .busy(busy_a)
  );

  parallel_in_serial_out #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b), .pdata(pdata_b),
    .sout(sout_b), .sout_valid(sv_b), .sout_last(sl_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // seq lists the transmitted bits first-to-last from bit 3 down to bit 0.
  task automatic exp_a(input logic [3:0] seq, input logic [3:0] word);
    for (int i = 3; i >= 0; i--) qa_bits.push_back({seq[i], (i == 0)});
    qa_words.push_back(word);
  endtask

  task automatic exp_b(input logic [3:0] seq, input logic [3:0] word);
    for (int i = 3; i >= 0; i--) qb_bits.push_back({seq[i], (i == 0)});
    qb_words.push_back(word);
  endtask

  // Behavioural partner receivers: LSB-first fills from the top, MSB-first from the bottom.
  always @(posedge clk) begin
    rx_a    <= {sout_a, rx_a[3:1]};
    rx_b    <= {rx_b[2:0], sout_b};
    lastd_a <= sv_a & sl_a;
    lastd_b <= sv_b & sl_b;
  end

  always @(negedge clk) begin
    if (sv_a === 1'b1) begin
      if (qa_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_stray_bit: got sout_valid=1 expected 0 at %0t", $time);
      end else begin
        logic [1:0] e;
        e = qa_bits.pop_front();
        chk("a_bit", 32'(sout_a), 32'(e[1]));
        chk("a_last", 32'(sl_a), 32'(e[0]));
      end
    end
    if (lastd_a === 1'b1 && qa_words.size() != 0) chk("a_rx_word", 32'(rx_a), 32'(qa_words.pop_front()));
  end

  always @(negedge clk) begin
    if (sv_b === 1'b1) begin
      if (qb_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_stray_bit: got sout_valid=1 expected 0 at %0t", $time);
      end else begin
        logic [1:0] e;
        e = qb_bits.pop_front();
        chk("b_bit", 32'(sout_b), 32'(e[1]));
        chk("b_last", 32'(sl_b), 32'(e[0]));
      end
    end
    if (lastd_b === 1'b1 && qb_words.size() != 0) chk("b_rx_word", 32'(rx_b), 32'(qb_words.pop_front()));
  end

  // Two words on instance A, the second offered exactly on the first's last bit.
  task automatic b2b_a(input logic [3:0] w1, input logic [3:0] s1,
                       input logic [3:0] w2, input logic [3:0] s2);
    pdata_a = w1;
    lv_a    = 1'b1;
    exp_a(s1, w1);
    tick;
    lv_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("b2b_valid_w1", 32'(sv_a), 32'd1);
      tick;
    end
    chk("b2b_ready_on_last", 32'(lr_a), 32'd1);
    chk("b2b_last_flag", 32'(sl_a), 32'd1);
    pdata_a = w2;
    lv_a    = 1'b1;
    exp_a(s2, w2);
    tick;
    lv_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_valid_w2", 32'(sv_a), 32'd1);
      tick;
    end
    chk("b2b_idle_after", 32'(sv_a), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    lv_a    = 1'b0;
    lv_b    = 1'b0;
    pdata_a = '0;
    pdata_b = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_sout", 32'(sout_a), 32'd0);
    chk("rst_valid", 32'(sv_a), 32'd0);
    chk("rst_last", 32'(sl_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(lr_a), 32'd1);
    chk("rst_ready_b", 32'(lr_b), 32'd1);

    // Single word 4'b1011 LSB-first: 1,1,0,1; pdata scrambled after accept.
    pdata_a = 4'b1011;
    lv_a    = 1'b1;
    exp_a(4'b1101, 4'hB);
    tick;
    lv_a    = 1'b0;
    pdata_a = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      chk("single_ready", 32'(lr_a), (i < 4) ? 32'd0 : 32'd1);
      chk("single_busy", 32'(busy_a), 32'd1);
      chk("single_valid", 32'(sv_a), 32'd1);
      tick;
    end
    chk("single_idle_valid", 32'(sv_a), 32'd0);
    chk("single_idle_busy", 32'(busy_a), 32'd0);
    chk("single_idle_ready", 32'(lr_a), 32'd1);

    // 4'hA then 4'h5: 0,1,0,1,1,0,1,0.
    b2b_a(4'hA, 4'b0101, 4'h5, 4'b1010);

    // MSB-first 4'b1011: 1,0,1,1.
    pdata_b = 4'b1011;
    lv_b    = 1'b1;
    exp_b(4'b1011, 4'hB);
    tick;
    lv_b = 1'b0;
    chk("msb_ready_busy", 32'(lr_b), 32'd0);
    repeat (4) tick;
    chk("msb_idle", 32'(sv_b), 32'd0);

    // Reset during the second bit of 4'hF.
    pdata_a = 4'hF;
    lv_a    = 1'b1;
    exp_a(4'b1111, 4'hF);
    tick;
    lv_a = 1'b0;
    tick;
    @(negedge clk);
    #1;
    qa_bits.delete();
    qa_words.delete();
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_valid", 32'(sv_a), 32'd0);
    chk("midrst_sout", 32'(sout_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ready", 32'(lr_a), 32'd1);
    repeat (4) tick;

    // Reset wins over a simultaneous load.
    rst     = 1'b1;
    lv_a    = 1'b1;
    pdata_a = 4'h3;
    tick;
    rst  = 1'b0;
    lv_a = 1'b0;
    chk("rst_vs_load_busy", 32'(busy_a), 32'd0);
    chk("rst_vs_load_valid", 32'(sv_a), 32'd0);
    tick;
    chk("rst_vs_load_valid2", 32'(sv_a), 32'd0);

    // Loopback words 4'h6 (0,1,1,0) then 4'h9 (1,0,0,1).
    b2b_a(4'h6, 4'b0110, 4'h9, 4'b1001);

    // load_valid held high on B: exactly one word per 4 cycles (1,1,0,0 twice).
    pdata_b = 4'hC;
    lv_b    = 1'b1;
    exp_b(4'b1100, 4'hC);
    exp_b(4'b1100, 4'hC);
    tick;
    chk("hold_ready_low", 32'(lr_b), 32'd0);
    repeat (4) tick;
    lv_b = 1'b0;
    repeat (4) tick;
    chk("hold_idle", 32'(sv_b), 32'd0);

    tick;
    chk("a_bits_drained", 32'(qa_bits.size()), 32'd0);
    chk("b_bits_drained", 32'(qb_bits.size()), 32'd0);
    chk("a_words_drained", 32'(qa_words.size()), 32'd0);
    chk("b_words_drained", 32'(qb_words.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
